// File: rtl/mem_arbiter.sv
// Two-port (fetch + data) arbiter onto one unified memory bus with fixed data priority,
// per-access timeout and fully registered outputs.
module mem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_rd,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY_IF = 2'd1;
    localparam logic [1:0] ST_BUSY_DM = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Counter value in the last BUSY cycle allowed before the access is aborted.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state_r,     state_s;
    logic [CW-1:0] cnt_r,       cnt_s;
    logic          mem_req_r,   mem_req_s;
    logic          mem_we_r,    mem_we_s;
    logic [31:0]   mem_addr_r,  mem_addr_s;
    logic [31:0]   mem_wdata_r, mem_wdata_s;
    logic [31:0]   if_rdata_r,  if_rdata_s;
    logic [31:0]   dm_rdata_r,  dm_rdata_s;
    logic          if_ready_r,  if_ready_s;
    logic          dm_ready_r,  dm_ready_s;
    logic          err_r,       err_s;

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        if_rdata_s  = if_rdata_r;
        dm_rdata_s  = dm_rdata_r;
        if_ready_s  = 1'b0;
        dm_ready_s  = 1'b0;
        err_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (dm_rd || dm_we) begin
                    state_s     = ST_BUSY_DM;
                    cnt_s       = {CW{1'b0}};
                    mem_req_s   = 1'b1;
                    mem_we_s    = dm_we;
                    mem_addr_s  = dm_addr;
                    mem_wdata_s = dm_wdata;
                end else if (if_req) begin
                    state_s     = ST_BUSY_IF;
                    cnt_s       = {CW{1'b0}};
                    mem_req_s   = 1'b1;
                    mem_we_s    = 1'b0;
                    mem_addr_s  = if_addr;
                end else begin
                    state_s     = ST_IDLE;
                end
            end

            ST_BUSY_IF, ST_BUSY_DM: begin
                // An ack in the final allowed cycle wins over the timeout.
                if (mem_ack) begin
                    state_s   = ST_DONE;
                    mem_req_s = 1'b0;
                    if (state_r == ST_BUSY_IF) begin
                        if_rdata_s = mem_rdata;
                        if_ready_s = 1'b1;
                    end else begin
                        dm_ready_s = 1'b1;
                        if (!mem_we_r) begin
                            dm_rdata_s = mem_rdata;
                        end else begin
                            dm_rdata_s = dm_rdata_r;
                        end
                    end
                end else if (cnt_r == CNT_LAST) begin
                    state_s   = ST_DONE;
                    mem_req_s = 1'b0;
                    err_s     = 1'b1;
                    if (state_r == ST_BUSY_IF) begin
                        if_ready_s = 1'b1;
                    end else begin
                        dm_ready_s = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end

            ST_DONE: begin
                state_s = ST_IDLE;
            end

            default: begin
                state_s   = ST_IDLE;
                mem_req_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            if_rdata_r  <= 32'h0000_0000;
            dm_rdata_r  <= 32'h0000_0000;
            if_ready_r  <= 1'b0;
            dm_ready_r  <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            if_rdata_r  <= if_rdata_s;
            dm_rdata_r  <= dm_rdata_s;
            if_ready_r  <= if_ready_s;
            dm_ready_r  <= dm_ready_s;
            err_r       <= err_s;
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign if_rdata  = if_rdata_r;
    assign dm_rdata  = dm_rdata_r;
    assign if_ready  = if_ready_r;
    assign dm_ready  = dm_ready_r;
    assign err       = err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner sequences and
// randomized traffic against a transaction-level memory/arbitration model.
module tb_mem_arbiter;

    localparam int TO    = 16;
    localparam int NEVER = 1000;

    logic        clk, rst;
    logic        if_req, dm_rd, dm_we, mem_ack, mem_req, mem_we;
    logic        if_ready, dm_ready, err;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    // memory responder controls
    int          lat_cfg = NEVER;
    logic [31:0] rd_val  = 32'h0;
    bit          stray   = 1'b0;
    bit          perturb_en = 1'b0;
    bit          was_req = 1'b0;
    int          busy_k  = 0;

    // transaction-level model state
    logic [31:0] mem_m [logic [31:0]];
    logic [31:0] exp_if, exp_dm;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_rd(dm_rd), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dm_rd, dm_we, if_req;
        logic [31:0] dm_addr, if_addr, wdata;
        int          lat;
        logic [31:0] rd;
        logic        e_dm, e_we;
        logic [31:0] e_addr;
        int          e_cyc;
        logic        e_err;
        logic [31:0] e_if, e_dmr;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a ^ 32'h5A5A_1234;
    endfunction

    // One clock: advance past the edge, then play the memory side for this cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (mem_req) begin
            if (was_req) busy_k++;
            else busy_k = 0;
        end
        was_req   = mem_req;
        mem_ack   = stray || (mem_req && (busy_k == lat_cfg));
        mem_rdata = mem_ack ? rd_val : $urandom;
    endtask

    // Wait for the ready pulse of one access and check everything about it.
    task automatic serve(input string nm, input int lat, input logic [31:0] rd,
                         input logic e_dm, input logic e_we, input logic [31:0] e_addr,
                         input logic [31:0] e_wdata, input int e_cyc, input logic e_err,
                         input logic [31:0] e_if, input logic [31:0] e_dmr);
        int n = 0;
        bit got = 1'b0, stab_ok = 1'b1, both = 1'b0;
        lat_cfg = lat;
        rd_val  = rd;
        while (!got && n < 64) begin
            cyc();
            n++;
            if (if_ready && dm_ready) both = 1'b1;
            if (mem_req) begin
                if (mem_addr !== e_addr || mem_we !== e_we || (e_we && mem_wdata !== e_wdata))
                    stab_ok = 1'b0;
                if (perturb_en) begin
                    dm_addr  = $urandom;
                    if_addr  = $urandom;
                    dm_wdata = $urandom;
                end
            end
            if (if_ready || dm_ready) got = 1'b1;
        end
        chk({nm, " completed"}, 32'(got), 32'd1);
        chk({nm, " latency"}, n, e_cyc);
        chk({nm, " port"}, {30'd0, dm_ready, if_ready}, e_dm ? 32'd2 : 32'd1);
        chk({nm, " err"}, 32'(err), 32'(e_err));
        chk({nm, " if_rdata"}, if_rdata, e_if);
        chk({nm, " dm_rdata"}, dm_rdata, e_dmr);
        chk({nm, " bus stable"}, 32'(stab_ok), 32'd1);
        chk({nm, " single ready"}, 32'(both), 32'd0);
        lat_cfg = NEVER;
    endtask

    task automatic finish_txn(input string nm);
        cyc();
        chk({nm, " idle mem_req"}, 32'(mem_req), 32'd0);
        chk({nm, " idle pulses"}, {29'd0, if_ready, dm_ready, err}, 32'd0);
    endtask

    initial begin
        int bits, lat;
        logic e_dm, e_we;
        logic [31:0] e_addr, rd;

        rst = 1'b1; if_req = 1'b0; dm_rd = 1'b0; dm_we = 1'b0;
        if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;

        tbl[0] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h100, 32'h0, 0, 32'h00500093,
                   1'b0, 1'b0, 32'h100, 2, 1'b0, 32'h00500093, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h2000, 32'h0, 32'h0, 2, 32'hDEADBEEF,
                   1'b1, 1'b0, 32'h2000, 4, 1'b0, 32'h00500093, 32'hDEADBEEF};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h2004, 32'h0, 32'hCAFEF00D, 3, 32'h77777777,
                   1'b1, 1'b1, 32'h2004, 5, 1'b0, 32'h00500093, 32'hDEADBEEF};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h2008, 32'h0, 32'h11112222, 1, 32'h55555555,
                   1'b1, 1'b1, 32'h2008, 3, 1'b0, 32'h00500093, 32'hDEADBEEF};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h200C, 32'h0, 32'h0, NEVER, 32'h66666666,
                   1'b1, 1'b0, 32'h200C, TO + 1, 1'b1, 32'h00500093, 32'hDEADBEEF};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h300, 32'h0, TO - 1, 32'h0BADF00D,
                   1'b0, 1'b0, 32'h300, TO + 1, 1'b0, 32'h0BADF00D, 32'hDEADBEEF};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h304, 32'h0, TO, 32'h99999999,
                   1'b0, 1'b0, 32'h304, TO + 1, 1'b1, 32'h0BADF00D, 32'hDEADBEEF};

        repeat (3) cyc();
        chk("reset ctrl", {27'd0, mem_req, mem_we, if_ready, dm_ready, err}, 32'd0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset mem_wdata", mem_wdata, 32'h0);
        chk("reset if_rdata", if_rdata, 32'h0);
        chk("reset dm_rdata", dm_rdata, 32'h0);
        rst = 1'b0;
        cyc();

        for (int i = 0; i < 7; i++) begin
            dm_rd = tbl[i].dm_rd; dm_we = tbl[i].dm_we; if_req = tbl[i].if_req;
            dm_addr = tbl[i].dm_addr; if_addr = tbl[i].if_addr; dm_wdata = tbl[i].wdata;
            serve($sformatf("vec%0d", i), tbl[i].lat, tbl[i].rd, tbl[i].e_dm, tbl[i].e_we,
                  tbl[i].e_addr, tbl[i].wdata, tbl[i].e_cyc, tbl[i].e_err,
                  tbl[i].e_if, tbl[i].e_dmr);
            dm_rd = 1'b0; dm_we = 1'b0; if_req = 1'b0;
            finish_txn($sformatf("vec%0d", i));
        end

        // simultaneous requests: data first, fetch afterwards
        if_req = 1'b1; if_addr = 32'h104; dm_rd = 1'b1; dm_addr = 32'h2000;
        serve("simul dm", 0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h2000, 32'h0, 2, 1'b0,
              32'h0BADF00D, 32'hDEADBEEF);
        dm_rd = 1'b0;
        serve("simul if", 0, 32'h12345678, 1'b0, 1'b0, 32'h104, 32'h0, 3, 1'b0,
              32'h12345678, 32'hDEADBEEF);
        if_req = 1'b0;
        finish_txn("simul");

        // back-to-back fetch with the request held high
        if_req = 1'b1; if_addr = 32'h108;
        serve("b2b 1", 0, 32'hA1A1A1A1, 1'b0, 1'b0, 32'h108, 32'h0, 2, 1'b0,
              32'hA1A1A1A1, 32'hDEADBEEF);
        serve("b2b 2", 1, 32'hB2B2B2B2, 1'b0, 1'b0, 32'h108, 32'h0, 4, 1'b0,
              32'hB2B2B2B2, 32'hDEADBEEF);
        if_req = 1'b0;
        finish_txn("b2b");

        // stray acks while idle must do nothing
        stray = 1'b1;
        cyc(); cyc();
        stray = 1'b0;
        cyc();
        chk("stray mem_req", 32'(mem_req), 32'd0);
        chk("stray pulses", {29'd0, if_ready, dm_ready, err}, 32'd0);
        chk("stray if_rdata", if_rdata, 32'hB2B2B2B2);

        // reset in the middle of a fetch, followed by a late ack
        if_req = 1'b1; if_addr = 32'h400;
        cyc();
        chk("rstmid busy", 32'(mem_req), 32'd1);
        cyc();
        rst = 1'b1; if_req = 1'b0;
        cyc();
        chk("rstmid ctrl", {27'd0, mem_req, mem_we, if_ready, dm_ready, err}, 32'd0);
        chk("rstmid mem_addr", mem_addr, 32'h0);
        chk("rstmid rdata", if_rdata | dm_rdata, 32'h0);
        rst = 1'b0; stray = 1'b1;
        cyc();
        stray = 1'b0;
        chk("rstmid late ack pulses", {29'd0, if_ready, dm_ready, err}, 32'd0);
        cyc();
        chk("rstmid after ack", {28'd0, mem_req, if_ready, dm_ready, err}, 32'd0);
        exp_if = 32'h0; exp_dm = 32'h0;

        // randomized traffic against the transaction model
        perturb_en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (!(dm_rd || dm_we || if_req)) begin
                bits = $urandom_range(1, 7);
                dm_rd = bits[0]; dm_we = bits[1]; if_req = bits[2];
                dm_addr = 32'($urandom_range(0, 7)) << 2;
                if_addr = 32'($urandom_range(0, 7)) << 2;
                dm_wdata = $urandom;
            end else if (!(dm_rd || dm_we) && $urandom_range(0, 3) == 0) begin
                dm_rd = 1'b1;
                dm_addr = 32'($urandom_range(0, 7)) << 2;
            end
            case ($urandom_range(0, 9))
                0:       lat = NEVER;
                1, 2:    lat = $urandom_range(TO - 2, TO + 1);
                default: lat = $urandom_range(0, 4);
            endcase
            e_dm   = dm_rd || dm_we;
            e_we   = e_dm && dm_we;
            e_addr = e_dm ? dm_addr : if_addr;
            rd     = mem_rd(e_addr);
            if (lat < TO) begin
                if (!e_dm) exp_if = rd;
                else if (!e_we) exp_dm = rd;
                else mem_m[e_addr] = dm_wdata;
            end
            serve($sformatf("rnd%0d", t), lat, rd, e_dm, e_we, e_addr, dm_wdata,
                  (lat < TO) ? lat + 2 : TO + 1, (lat >= TO), exp_if, exp_dm);
            if (e_dm) begin
                dm_rd = 1'b0; dm_we = 1'b0;
            end else begin
                if_req = 1'b0;
            end
            finish_txn($sformatf("rnd%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
